// File: rtl/rob_commit_if.sv
// Dispatch / CDB / retire bundle of the reorder buffer.
// Forwarding query signals exist only when ROB_FWD_EN is defined.
interface rob_commit_if #(
    parameter int unsigned TAG_W = 5
) ();
    logic             rdy;
    logic             alloc_valid;
    logic             alloc_rd_hv;
    logic [4:0]       alloc_rd;
    logic             alloc_is_br;
    logic             alloc_pred_taken;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_value;
    logic             wb_br_taken;
    logic [31:0]      wb_br_target;
    logic             commit_valid;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_res;
    logic [TAG_W-1:0] commit_tag;
    logic             flush;
    logic [31:0]      flush_pc;
`ifdef ROB_FWD_EN
    logic [TAG_W-1:0] q1_tag;
    logic [TAG_W-1:0] q2_tag;
    logic             q1_ready;
    logic             q2_ready;
    logic [31:0]      q1_value;
    logic [31:0]      q2_value;
`endif

    modport master (
        output rdy, alloc_valid, alloc_rd_hv, alloc_rd, alloc_is_br, alloc_pred_taken,
        output wb_valid, wb_tag, wb_value, wb_br_taken, wb_br_target,
        input  alloc_ready, alloc_tag, commit_valid, commit_rd, commit_res, commit_tag,
        input  flush, flush_pc
`ifdef ROB_FWD_EN
        , output q1_tag, q2_tag
        , input  q1_ready, q2_ready, q1_value, q2_value
`endif
    );

    modport slave (
        input  rdy, alloc_valid, alloc_rd_hv, alloc_rd, alloc_is_br, alloc_pred_taken,
        input  wb_valid, wb_tag, wb_value, wb_br_taken, wb_br_target,
        output alloc_ready, alloc_tag, commit_valid, commit_rd, commit_res, commit_tag,
        output flush, flush_pc
`ifdef ROB_FWD_EN
        , input  q1_tag, q2_tag
        , output q1_ready, q2_ready, q1_value, q2_value
`endif
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: allocates rename tags, collects CDB results, retires in order, raises mispredict flush.
// Optional ROB_FWD_EN adds two operand-forwarding query ports.
module rob_commit #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    rob_commit_if.slave   rob
);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        is_br;
        logic        pred;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flush_pend_q, flush_pend_d;
    logic [31:0]      flush_pc_q, flush_pc_d;

    entry_t           hd;
    logic             do_alloc;
    logic             do_commit;
    logic             wb_hit;
    logic             mispredict;
    logic [IDX_W-1:0] wb_idx;

    assign hd         = ent_q[head_q];
    assign wb_idx     = IDX_W'(rob.wb_tag - TAG_W'(1));
    assign wb_hit     = rob.wb_valid && (rob.wb_tag != '0) &&
                        (rob.wb_tag <= TAG_W'(DEPTH)) && ent_q[wb_idx].busy;
    assign mispredict = hd.is_br && (hd.taken != hd.pred);

    // Combinational handshake and retire view of the head entry
    assign rob.alloc_ready  = rob.rdy && (count_q != CNT_W'(DEPTH)) && !flush_pend_q;
    assign rob.alloc_tag    = TAG_W'(tail_q) + TAG_W'(1);
    assign rob.commit_valid = rob.rdy && (count_q != '0) && hd.busy && hd.done && !flush_pend_q;
    assign rob.commit_rd    = hd.rd;
    assign rob.commit_res   = hd.value;
    assign rob.commit_tag   = TAG_W'(head_q) + TAG_W'(1);
    assign rob.flush        = flush_pend_q;
    assign rob.flush_pc     = flush_pc_q;

    assign do_alloc  = rob.alloc_valid && rob.alloc_ready;
    assign do_commit = rob.commit_valid;

    always_comb begin
        ent_d        = ent_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        flush_pend_d = flush_pend_q;
        flush_pc_d   = flush_pc_q;
        if (flush_pend_q) begin
            // Flush cycle: drop everything, including any writeback arriving now
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i].busy = 1'b0;
                ent_d[i].done = 1'b0;
            end
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            flush_pend_d = 1'b0;
        end else begin
            if (wb_hit) begin
                ent_d[wb_idx].done   = 1'b1;
                ent_d[wb_idx].value  = rob.wb_value;
                ent_d[wb_idx].taken  = rob.wb_br_taken;
                ent_d[wb_idx].target = rob.wb_br_target;
            end
            if (do_alloc) begin
                ent_d[tail_q].busy  = 1'b1;
                ent_d[tail_q].done  = 1'b0;
                ent_d[tail_q].rd    = rob.alloc_rd_hv ? rob.alloc_rd : 5'd0;
                ent_d[tail_q].is_br = rob.alloc_is_br;
                ent_d[tail_q].pred  = rob.alloc_pred_taken;
                tail_d              = tail_q + IDX_W'(1);
            end
            if (do_commit) begin
                ent_d[head_q].busy = 1'b0;
                head_d             = head_q + IDX_W'(1);
                if (mispredict) begin
                    flush_pend_d = 1'b1;
                    flush_pc_d   = hd.target;
                end
            end
            case ({do_alloc, do_commit})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // rdy low freezes every register, including a pending flush
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
            flush_pc_q   <= '0;
        end else if (rob.rdy) begin
            ent_q        <= ent_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
            flush_pc_q   <= flush_pc_d;
        end
    end

`ifdef ROB_FWD_EN
    logic [IDX_W-1:0] q1_idx, q2_idx;
    logic             q1_hit, q2_hit, q1_byp, q2_byp;

    assign q1_idx = IDX_W'(rob.q1_tag - TAG_W'(1));
    assign q2_idx = IDX_W'(rob.q2_tag - TAG_W'(1));
    assign q1_hit = (rob.q1_tag != '0) && (rob.q1_tag <= TAG_W'(DEPTH)) &&
                    ent_q[q1_idx].busy && ent_q[q1_idx].done;
    assign q2_hit = (rob.q2_tag != '0) && (rob.q2_tag <= TAG_W'(DEPTH)) &&
                    ent_q[q2_idx].busy && ent_q[q2_idx].done;
    assign q1_byp = rob.wb_valid && (rob.q1_tag != '0) && (rob.wb_tag == rob.q1_tag);
    assign q2_byp = rob.wb_valid && (rob.q2_tag != '0) && (rob.wb_tag == rob.q2_tag);

    // Stored result takes precedence; otherwise bypass the CDB value of this cycle
    assign rob.q1_ready = q1_hit || q1_byp;
    assign rob.q2_ready = q2_hit || q2_byp;
    assign rob.q1_value = q1_hit ? ent_q[q1_idx].value : (q1_byp ? rob.wb_value : 32'd0);
    assign rob.q2_value = q2_hit ? ent_q[q2_idx].value : (q2_byp ? rob.wb_value : 32'd0);
`else
    // Without forwarding, dispatch waits on the CDB only.
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: stimulus queues expected retirements/flushes, a monitor checks them.
module tb_rob_commit;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t        exp_q [$];
    logic [31:0] fl_q  [$];

    always #5 clk = ~clk;

    rob_commit_if #(.TAG_W(5)) bus ();
    rob_commit dut (.clk(clk), .rst(rst), .rob(bus));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic alloc(input logic hv, input logic [4:0] rd, input logic br, input logic pred);
        bus.alloc_valid      = 1'b1;
        bus.alloc_rd_hv      = hv;
        bus.alloc_rd         = rd;
        bus.alloc_is_br      = br;
        bus.alloc_pred_taken = pred;
    endtask

    task automatic wb(input logic [4:0] tag, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
        bus.wb_valid     = 1'b1;
        bus.wb_tag       = tag;
        bus.wb_value     = val;
        bus.wb_br_taken  = tk;
        bus.wb_br_target = tgt;
    endtask

    task automatic expect_commit(input logic [4:0] rd, input logic [31:0] res, input logic [4:0] tag);
        exp_t e;
        e.rd  = rd;
        e.res = res;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b1;
        bus.alloc_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1;
        bus.alloc_valid = 1'b0;
        bus.alloc_rd_hv = 1'b0;
        bus.alloc_rd = 5'd0;
        bus.alloc_is_br = 1'b0;
        bus.alloc_pred_taken = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_tag = 5'd0;
        bus.wb_value = 32'd0;
        bus.wb_br_taken = 1'b0;
        bus.wb_br_target = 32'd0;
`ifdef ROB_FWD_EN
        bus.q1_tag = 5'd0;
        bus.q2_tag = 5'd0;
`endif

        // Monitor: compares every retirement and flush against the queues
        fork
            begin : monitor
                exp_t e;
                logic [31:0] p;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        if (bus.commit_valid === 1'b1) begin
                            if (exp_q.size() == 0) begin
                                chk("commit_unexpected", {27'd0, bus.commit_tag}, 32'd0);
                            end else begin
                                e = exp_q.pop_front();
                                chk("commit_rd", {27'd0, bus.commit_rd}, {27'd0, e.rd});
                                chk("commit_res", bus.commit_res, e.res);
                                chk("commit_tag", {27'd0, bus.commit_tag}, {27'd0, e.tag});
                            end
                        end
                        if (bus.flush === 1'b1) begin
                            if (fl_q.size() == 0) begin
                                chk("flush_unexpected", {31'd0, bus.flush}, 32'd0);
                            end else begin
                                p = fl_q.pop_front();
                                chk("flush_pc", bus.flush_pc, p);
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        smp();
        chk("rst_commit_valid", {31'd0, bus.commit_valid}, 32'd0);
        chk("rst_commit_rd", {27'd0, bus.commit_rd}, 32'd0);
        chk("rst_commit_res", bus.commit_res, 32'd0);
        chk("rst_commit_tag", {27'd0, bus.commit_tag}, 32'd1);
        chk("rst_alloc_ready", {31'd0, bus.alloc_ready}, 32'd1);
        chk("rst_alloc_tag", {27'd0, bus.alloc_tag}, 32'd1);
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_flush_pc", bus.flush_pc, 32'd0);

        // Three allocations, out-of-order writeback, in-order retirement
        nxt(); alloc(1'b1, 5'd5, 1'b0, 1'b0); expect_commit(5'd5, 32'h11, 5'd1);
        smp(); chk("a_tag1", {27'd0, bus.alloc_tag}, 32'd1);
        nxt(); alloc(1'b1, 5'd6, 1'b0, 1'b0); expect_commit(5'd6, 32'hAA, 5'd2);
        smp(); chk("a_tag2", {27'd0, bus.alloc_tag}, 32'd2);
        nxt(); alloc(1'b0, 5'd9, 1'b0, 1'b0); expect_commit(5'd0, 32'h33, 5'd3);
        smp(); chk("a_tag3", {27'd0, bus.alloc_tag}, 32'd3);
        nxt(); bus.alloc_valid = 1'b0; wb(5'd2, 32'hAA, 1'b0, 32'd0);
        smp(); chk("a_tag4", {27'd0, bus.alloc_tag}, 32'd4);
        chk("a_no_commit0", {31'd0, bus.commit_valid}, 32'd0);
        nxt(); wb(5'd1, 32'h11, 1'b0, 32'd0);
`ifdef ROB_FWD_EN
        bus.q1_tag = 5'd2;
        bus.q2_tag = 5'd1;
`endif
        smp(); chk("a_no_commit1", {31'd0, bus.commit_valid}, 32'd0);
`ifdef ROB_FWD_EN
        chk("fwd_q1_ready", {31'd0, bus.q1_ready}, 32'd1);
        chk("fwd_q1_value", bus.q1_value, 32'hAA);
        chk("fwd_q2_ready_byp", {31'd0, bus.q2_ready}, 32'd1);
        chk("fwd_q2_value_byp", bus.q2_value, 32'h11);
`endif
        nxt(); bus.wb_valid = 1'b0;
`ifdef ROB_FWD_EN
        bus.q1_tag = 5'd0;
`endif
        smp();
`ifdef ROB_FWD_EN
        chk("fwd_tag0_ready", {31'd0, bus.q1_ready}, 32'd0);
        chk("fwd_tag0_value", bus.q1_value, 32'd0);
`endif
        nxt(); smp();
        nxt(); wb(5'd3, 32'h33, 1'b0, 32'd0);
        smp(); chk("a_no_commit3", {31'd0, bus.commit_valid}, 32'd0);
        nxt(); bus.wb_valid = 1'b0; smp();
        nxt(); smp();
        chk("a_empty_commit", {31'd0, bus.commit_valid}, 32'd0);
        chk("a_empty_tag", {27'd0, bus.alloc_tag}, 32'd4);

        // Fill all 16 entries; full blocks alloc even with a simultaneous commit
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(1'b1, 5'(i + 1), 1'b0, 1'b0);
            smp();
            chk("f_tag", {27'd0, bus.alloc_tag}, 32'(i + 1));
            chk("f_ready", {31'd0, bus.alloc_ready}, 32'd1);
            nxt();
        end
        wb(5'd1, 32'h100, 1'b0, 32'd0); expect_commit(5'd1, 32'h100, 5'd1);
        smp(); chk("f_full_ready", {31'd0, bus.alloc_ready}, 32'd0);
        chk("f_full_tag", {27'd0, bus.alloc_tag}, 32'd1);
        nxt(); bus.wb_valid = 1'b0;
        smp(); chk("f_commit_blocks", {31'd0, bus.alloc_ready}, 32'd0);
        nxt(); smp();
        chk("f_wrap_ready", {31'd0, bus.alloc_ready}, 32'd1);
        chk("f_wrap_tag", {27'd0, bus.alloc_tag}, 32'd1);
        nxt(); bus.alloc_valid = 1'b0;
        smp(); chk("f_refull_ready", {31'd0, bus.alloc_ready}, 32'd0);
        chk("f_refull_tag", {27'd0, bus.alloc_tag}, 32'd2);

        // Mispredicted branch at head, younger entries already done
        do_reset();
        alloc(1'b0, 5'd0, 1'b1, 1'b0); expect_commit(5'd0, 32'd0, 5'd1);
        smp(); chk("b_tag1", {27'd0, bus.alloc_tag}, 32'd1);
        nxt(); alloc(1'b1, 5'd3, 1'b0, 1'b0); smp();
        nxt(); alloc(1'b1, 5'd4, 1'b0, 1'b0); smp();
        nxt(); bus.alloc_valid = 1'b0; wb(5'd2, 32'h22, 1'b0, 32'd0); smp();
        nxt(); wb(5'd3, 32'h33, 1'b0, 32'd0); smp();
        nxt(); wb(5'd1, 32'd0, 1'b1, 32'h1000);
        smp(); chk("b_no_commit", {31'd0, bus.commit_valid}, 32'd0);
        nxt(); bus.wb_valid = 1'b0; fl_q.push_back(32'h1000);
        smp(); chk("b_n_flush", {31'd0, bus.flush}, 32'd0);
        nxt(); wb(5'd2, 32'hDEAD, 1'b0, 32'd0);
        smp(); chk("b_n1_flush", {31'd0, bus.flush}, 32'd1);
        chk("b_n1_flush_pc", bus.flush_pc, 32'h1000);
        chk("b_n1_commit", {31'd0, bus.commit_valid}, 32'd0);
        chk("b_n1_alloc_ready", {31'd0, bus.alloc_ready}, 32'd0);
        nxt(); bus.wb_valid = 1'b0;
        smp(); chk("b_n2_flush", {31'd0, bus.flush}, 32'd0);
        chk("b_n2_alloc_tag", {27'd0, bus.alloc_tag}, 32'd1);
        chk("b_n2_alloc_ready", {31'd0, bus.alloc_ready}, 32'd1);
        chk("b_n2_commit", {31'd0, bus.commit_valid}, 32'd0);
        repeat (3) begin nxt(); smp(); end

        // rdy low freezes a done head and a pending allocation
        nxt(); alloc(1'b1, 5'd10, 1'b0, 1'b0); expect_commit(5'd10, 32'h55, 5'd1); smp();
        nxt(); bus.alloc_valid = 1'b0; wb(5'd1, 32'h55, 1'b0, 32'd0); smp();
        nxt(); bus.wb_valid = 1'b0; bus.rdy = 1'b0; alloc(1'b1, 5'd11, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("r_commit_frozen", {31'd0, bus.commit_valid}, 32'd0);
            chk("r_alloc_frozen", {31'd0, bus.alloc_ready}, 32'd0);
            chk("r_tag_frozen", {27'd0, bus.alloc_tag}, 32'd2);
            nxt();
        end
        bus.rdy = 1'b1;
        smp(); chk("r_resume_ready", {31'd0, bus.alloc_ready}, 32'd1);
        chk("r_resume_tag", {27'd0, bus.alloc_tag}, 32'd2);
        nxt(); bus.alloc_valid = 1'b0;
        smp(); chk("r_after_tag", {27'd0, bus.alloc_tag}, 32'd3);
        chk("r_after_commit", {31'd0, bus.commit_valid}, 32'd0);
        nxt(); smp();

        chk("sb_commits_left", 32'(exp_q.size()), 32'd0);
        chk("sb_flushes_left", 32'(fl_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
